axis_byte_packer: RTL and testbench

AXIS_BYTE_PACKER -- requirements
Module: axis_byte_packer

---
 rtl/axis_pack_pkg.sv | 19 +
 rtl/axis_out_reg.sv | 40 ++++
 rtl/axis_byte_packer.sv | 88 ++++++++
 tb/tb_axis_byte_packer.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/axis_pack_pkg.sv
// Shared defaults and helpers for the AXI-Stream byte packer.
package axis_pack_pkg;

  localparam int unsigned OUT_BYTES_DEF = 4;
  localparam int unsigned CNT_W_DEF     = 16;
  localparam int unsigned MAX_BYTES     = 8;
  localparam int unsigned LANE_IDX_W    = 3;

  // Ones in lanes 0..idx, zeros above.
  function automatic logic [MAX_BYTES-1:0] keep_mask(input logic [LANE_IDX_W-1:0] idx);
    logic [MAX_BYTES-1:0] m;
    m = '0;
    for (int i = 0; i < MAX_BYTES; i++) begin
      m[i] = (LANE_IDX_W'(i) <= idx);
    end
    return m;
  endfunction

endpackage

// File: rtl/axis_out_reg.sv
// Output word holding register with AXIS stall/handshake logic.
module axis_out_reg #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned KEEP_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic [KEEP_W-1:0] load_keep,
  input  logic              load_last,
  input  logic              m_axis_tready,
  output logic              m_axis_tvalid,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic [KEEP_W-1:0] m_axis_tkeep,
  output logic              m_axis_tlast,
  output logic              ready_c
);

  // Upstream may only proceed when the held word is absent or leaving now.
  assign ready_c = ~(m_axis_tvalid & ~m_axis_tready);

  // Load a completed word, otherwise drop valid once the word is taken.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tkeep  <= '0;
      m_axis_tlast  <= 1'b0;
    end else if (load) begin
      m_axis_tvalid <= 1'b1;
      m_axis_tdata  <= load_data;
      m_axis_tkeep  <= load_keep;
      m_axis_tlast  <= load_last;
    end else if (m_axis_tvalid && m_axis_tready) begin
      m_axis_tvalid <= 1'b0;
    end
  end

endmodule

// File: rtl/axis_byte_packer.sv
// Packs an AXI-Stream byte stream into little-endian OUT_BYTES-wide words.
module axis_byte_packer
  import axis_pack_pkg::*;
#(
  parameter int unsigned OUT_BYTES = OUT_BYTES_DEF,
  parameter int unsigned CNT_W     = CNT_W_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   s_axis_tvalid,
  input  logic [7:0]             s_axis_tdata,
  input  logic                   s_axis_tlast,
  output logic                   s_axis_tready,
  output logic                   m_axis_tvalid,
  output logic [8*OUT_BYTES-1:0] m_axis_tdata,
  output logic [OUT_BYTES-1:0]   m_axis_tkeep,
  output logic                   m_axis_tlast,
  input  logic                   m_axis_tready,
  output logic [CNT_W-1:0]       pkt_count
);

  localparam int unsigned DATA_W = 8 * OUT_BYTES;
  localparam int unsigned IDX_W  = $clog2(OUT_BYTES);

  logic [IDX_W-1:0]     idx;
  logic [DATA_W-1:0]    acc;
  logic                 accept_c;
  logic                 complete_c;
  logic [OUT_BYTES-1:0] new_keep_c;
  logic [DATA_W-1:0]    lane_mask_c;
  logic [DATA_W-1:0]    new_word_c;

  // Byte acceptance and word completion decode.
  assign accept_c   = s_axis_tvalid & s_axis_tready;
  assign complete_c = accept_c & (s_axis_tlast | (idx == IDX_W'(OUT_BYTES - 1)));

  // Assemble the outgoing word: accumulated lanes plus the new byte, unused lanes zeroed.
  always_comb begin
    new_keep_c  = OUT_BYTES'(keep_mask(LANE_IDX_W'(idx)));
    lane_mask_c = '0;
    for (int i = 0; i < OUT_BYTES; i++) begin
      lane_mask_c[8*i +: 8] = {8{new_keep_c[i]}};
    end
    new_word_c = (acc | (DATA_W'(s_axis_tdata) << {idx, 3'b000})) & lane_mask_c;
  end

  // Lane accumulator and write index.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      idx <= '0;
      acc <= '0;
    end else if (complete_c) begin
      idx <= '0;
      acc <= '0;
    end else if (accept_c) begin
      idx                  <= idx + IDX_W'(1);
      acc[{idx, 3'b000} +: 8] <= s_axis_tdata;
    end
  end

  axis_out_reg #(
    .DATA_W (DATA_W),
    .KEEP_W (OUT_BYTES)
  ) u_out_reg (
    .clk           (clk),
    .rst_n         (rst_n),
    .load          (complete_c),
    .load_data     (new_word_c),
    .load_keep     (new_keep_c),
    .load_last     (s_axis_tlast),
    .m_axis_tready (m_axis_tready),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tkeep  (m_axis_tkeep),
    .m_axis_tlast  (m_axis_tlast),
    .ready_c       (s_axis_tready)
  );

  // Count packets as their last word leaves; wraps naturally.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      pkt_count <= '0;
    end else if (m_axis_tvalid && m_axis_tready && m_axis_tlast) begin
      pkt_count <= pkt_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_axis_byte_packer.sv
// Directed table-driven bench for axis_byte_packer (4-byte words, plus a 4-bit counter instance).
module tb_axis_byte_packer;

  typedef struct packed {
    logic        v;
    logic [7:0]  d;
    logic        l;
    logic        mr;
    logic        sr;
    logic        mv;
    logic [31:0] wd;
    logic [3:0]  wk;
    logic        wl;
    logic [15:0] cnt;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        s_v = 1'b0;
  logic [7:0]  s_d = 8'h00;
  logic        s_l = 1'b0;
  logic        m_r = 1'b0;

  logic        s_rdy, m_v, m_l;
  logic [31:0] m_d;
  logic [3:0]  m_k;
  logic [15:0] cnt16;

  logic        s_rdy4, m_v4, m_l4;
  logic [31:0] m_d4;
  logic [3:0]  m_k4;
  logic [3:0]  cnt4;

  int n_checks = 0;
  int n_fail   = 0;

  vec_t tbl [20];

  always #5 clk = ~clk;

  axis_byte_packer #(.OUT_BYTES(4), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_axis_tvalid(s_v), .s_axis_tdata(s_d), .s_axis_tlast(s_l), .s_axis_tready(s_rdy),
    .m_axis_tvalid(m_v), .m_axis_tdata(m_d), .m_axis_tkeep(m_k), .m_axis_tlast(m_l),
    .m_axis_tready(m_r), .pkt_count(cnt16)
  );

  axis_byte_packer #(.OUT_BYTES(4), .CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n),
    .s_axis_tvalid(s_v), .s_axis_tdata(s_d), .s_axis_tlast(s_l), .s_axis_tready(s_rdy4),
    .m_axis_tvalid(m_v4), .m_axis_tdata(m_d4), .m_axis_tkeep(m_k4), .m_axis_tlast(m_l4),
    .m_axis_tready(m_r), .pkt_count(cnt4)
  );

  function automatic vec_t mkv(input logic v, input logic [7:0] d, input logic l, input logic mr,
                               input logic sr, input logic mv, input logic [31:0] wd,
                               input logic [3:0] wk, input logic wl, input logic [15:0] cnt);
    vec_t t;
    t.v = v; t.d = d; t.l = l; t.mr = mr; t.sr = sr; t.mv = mv;
    t.wd = wd; t.wk = wk; t.wl = wl; t.cnt = cnt;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Drive one cycle of stimulus, check ready before the edge and outputs after it.
  task automatic step(input vec_t t, input string nm);
    s_v = t.v; s_d = t.d; s_l = t.l; m_r = t.mr;
    #1;
    chk({nm, "/s_tready"}, 64'(s_rdy), 64'(t.sr));
    @(posedge clk);
    #1;
    chk({nm, "/m_tvalid"}, 64'(m_v), 64'(t.mv));
    chk({nm, "/m_tdata"},  64'(m_d), 64'(t.wd));
    chk({nm, "/m_tkeep"},  64'(m_k), 64'(t.wk));
    chk({nm, "/m_tlast"},  64'(m_l), 64'(t.wl));
    chk({nm, "/pkt_count"}, 64'(cnt16), 64'(t.cnt));
  endtask

  task automatic check_reset_state(input string nm);
    chk({nm, "/rst m_tvalid"}, 64'(m_v), 64'd0);
    chk({nm, "/rst m_tdata"},  64'(m_d), 64'd0);
    chk({nm, "/rst m_tkeep"},  64'(m_k), 64'd0);
    chk({nm, "/rst m_tlast"},  64'(m_l), 64'd0);
    chk({nm, "/rst pkt_count"}, 64'(cnt16), 64'd0);
    chk({nm, "/rst pkt_count4"}, 64'(cnt4), 64'd0);
    chk({nm, "/rst s_tready"}, 64'(s_rdy), 64'd1);
  endtask

  initial begin
    int words;
    logic ready_seen_low;
    logic [7:0] b;

    //          v  data   l  mr  sr mv word          keep  l  cnt
    // AA,55,FF,01 -> 01FF55AA
    tbl[0]  = mkv(1, 8'hAA, 0, 1, 1, 0, 32'h0,        4'h0, 0, 16'd0);
    tbl[1]  = mkv(1, 8'h55, 0, 1, 1, 0, 32'h0,        4'h0, 0, 16'd0);
    tbl[2]  = mkv(1, 8'hFF, 0, 1, 1, 0, 32'h0,        4'h0, 0, 16'd0);
    tbl[3]  = mkv(1, 8'h01, 1, 1, 1, 1, 32'h01FF55AA, 4'hF, 1, 16'd0);
    tbl[4]  = mkv(0, 8'h00, 0, 1, 1, 0, 32'h01FF55AA, 4'hF, 1, 16'd1);
    // 11,22 -> 00002211; then 7E loaded on the same edge the previous word leaves
    tbl[5]  = mkv(1, 8'h11, 0, 1, 1, 0, 32'h01FF55AA, 4'hF, 1, 16'd1);
    tbl[6]  = mkv(1, 8'h22, 1, 1, 1, 1, 32'h00002211, 4'h3, 1, 16'd1);
    tbl[7]  = mkv(1, 8'h7E, 1, 1, 1, 1, 32'h0000007E, 4'h1, 1, 16'd2);
    tbl[8]  = mkv(0, 8'h00, 0, 1, 1, 0, 32'h0000007E, 4'h1, 1, 16'd3);
    // 00..07 with downstream stalled, then released
    tbl[9]  = mkv(1, 8'h00, 0, 0, 1, 0, 32'h0000007E, 4'h1, 1, 16'd3);
    tbl[10] = mkv(1, 8'h01, 0, 0, 1, 0, 32'h0000007E, 4'h1, 1, 16'd3);
    tbl[11] = mkv(1, 8'h02, 0, 0, 1, 0, 32'h0000007E, 4'h1, 1, 16'd3);
    tbl[12] = mkv(1, 8'h03, 0, 0, 1, 1, 32'h03020100, 4'hF, 0, 16'd3);
    tbl[13] = mkv(1, 8'h04, 0, 0, 0, 1, 32'h03020100, 4'hF, 0, 16'd3);
    tbl[14] = mkv(1, 8'h04, 0, 0, 0, 1, 32'h03020100, 4'hF, 0, 16'd3);
    tbl[15] = mkv(1, 8'h04, 0, 1, 1, 0, 32'h03020100, 4'hF, 0, 16'd3);
    tbl[16] = mkv(1, 8'h05, 0, 1, 1, 0, 32'h03020100, 4'hF, 0, 16'd3);
    tbl[17] = mkv(1, 8'h06, 0, 1, 1, 0, 32'h03020100, 4'hF, 0, 16'd3);
    tbl[18] = mkv(1, 8'h07, 1, 1, 1, 1, 32'h07060504, 4'hF, 1, 16'd3);
    tbl[19] = mkv(0, 8'h00, 0, 1, 1, 0, 32'h07060504, 4'hF, 1, 16'd4);

    // Power-on reset
    repeat (3) @(posedge clk);
    #1;
    check_reset_state("por");
    rst_n = 1'b0;

    for (int i = 0; i < 20; i++) begin
      step(tbl[i], $sformatf("vec%0d", i));
    end

    // 64-byte packet at full rate
    words = 0;
    ready_seen_low = 1'b0;
    for (int i = 0; i < 64; i++) begin
      s_v = 1'b1; s_d = 8'(i); s_l = (i == 63); m_r = 1'b1;
      #1;
      if (!s_rdy) ready_seen_low = 1'b1;
      @(posedge clk);
      #1;
      if (m_v) words++;
      if ((i % 4) == 3) begin
        chk($sformatf("burst word %0d", i / 4), {31'd0, m_v, m_d},
            {31'd0, 1'b1, 8'(i), 8'(i - 1), 8'(i - 2), 8'(i - 3)});
      end
    end
    chk("burst word count", 64'(words), 64'd16);
    chk("burst s_tready low", 64'(ready_seen_low), 64'd0);
    step(mkv(0, 8'h00, 0, 1, 1, 0, 32'h3F3E3D3C, 4'hF, 1, 16'd5), "burst drain");

    // Reset mid-packet
    step(mkv(1, 8'h11, 0, 1, 1, 0, 32'h3F3E3D3C, 4'hF, 1, 16'd5), "mid 11");
    step(mkv(1, 8'h22, 0, 1, 1, 0, 32'h3F3E3D3C, 4'hF, 1, 16'd5), "mid 22");
    s_v = 1'b0;
    rst_n = 1'b1;
    #1;
    check_reset_state("midrst");
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    step(mkv(1, 8'hAA, 0, 1, 1, 0, 32'h0,        4'h0, 0, 16'd0), "post AA");
    step(mkv(1, 8'hBB, 0, 1, 1, 0, 32'h0,        4'h0, 0, 16'd0), "post BB");
    step(mkv(1, 8'hCC, 0, 1, 1, 0, 32'h0,        4'h0, 0, 16'd0), "post CC");
    step(mkv(1, 8'hDD, 1, 1, 1, 1, 32'hDDCCBBAA, 4'hF, 1, 16'd0), "post DD");
    step(mkv(0, 8'h00, 0, 1, 1, 0, 32'hDDCCBBAA, 4'hF, 1, 16'd1), "post drain");

    // Held word discarded by reset
    step(mkv(1, 8'h55, 1, 0, 1, 1, 32'h00000055, 4'h1, 1, 16'd1), "held 55");
    step(mkv(0, 8'h00, 0, 0, 0, 1, 32'h00000055, 4'h1, 1, 16'd1), "held stall");
    rst_n = 1'b1;
    #1;
    check_reset_state("heldrst");
    @(posedge clk);
    #1;
    rst_n = 1'b0;

    // 17 one-byte packets: 16-bit counter reaches 17, 4-bit counter wraps to 1
    for (int i = 0; i < 17; i++) begin
      b = 8'(i + 8'h40);
      step(mkv(1, b, 1, 1, 1, 1, {24'd0, b}, 4'h1, 1, 16'(i)), $sformatf("one-byte %0d", i));
    end
    step(mkv(0, 8'h00, 0, 1, 1, 0, 32'h00000050, 4'h1, 1, 16'd17), "one-byte drain");
    chk("pkt_count wrap", 64'(cnt4), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
